regfile_wb_arbiter: RTL

Write-port arbiter and scoreboard for the 32x32 register file. It shares the single regfile write port between the in-order pipeline writeback and a multi-cycle unit (divider or late load return). Multi-cycle results are buffered in a small FIFO. A pending-register scoreboard raises a stall request when a pipeline read targets a register that still awaits a multi-cycle result. The block sits between the WB stage, the multi-cycle unit and the regfile write port, and its stall request feeds the stall controller.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/wb_fifo.sv | 43 ++++
 rtl/regfile_wb_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file widths and the writeback entry carried through the multi-cycle result FIFO.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_NUM    = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; head visible the cycle after push, pop takes effect at the edge.
// Backpressure: full is registered state; pushes while full and pops while empty are ignored.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_dat,
  input  logic      pop,
  output wb_entry_t head_dat,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter + pending scoreboard; pipeline write 1 cycle to we, multi-cycle result >=2 cycles.
// Backpressure: m_ready drops when the FIFO is full; starved FIFO head raises pipe_hold, stall_req guards reads.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_we,
  input  logic [REG_ADDR_W-1:0] p_waddr,
  input  logic [REG_DATA_W-1:0] p_wdata,
  input  logic                  m_valid,
  input  logic [REG_ADDR_W-1:0] m_waddr,
  input  logic [REG_DATA_W-1:0] m_wdata,
  output logic                  m_ready,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_waddr,
  input  logic                  re1,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic                  re2,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [REG_DATA_W-1:0] wdata,
  output logic                  stall_req,
  output logic                  pipe_hold,
  output logic                  err
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  wb_entry_t          push_dat;
  wb_entry_t          head_dat;
  logic               p_win;
  logic               iss_set;
  logic               src_m;
  logic [CW-1:0]      wait_cnt;
  logic [REG_NUM-1:0] pending;
  logic [REG_NUM-1:0] pending_nxt;

  assign m_ready   = !fifo_full;
  assign p_win     = p_we && (p_waddr != ZERO_REG);
  assign iss_set   = iss_valid && (iss_waddr != ZERO_REG);
  // r0 results are accepted from the unit but never stored.
  assign fifo_push = m_valid && m_ready && (m_waddr != ZERO_REG);
  assign fifo_pop  = !p_win && !fifo_empty;
  assign push_dat  = '{addr: m_waddr, data: m_wdata};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign stall_req = (re1 && (raddr1 != ZERO_REG) && pending[raddr1]) ||
                     (re2 && (raddr2 != ZERO_REG) && pending[raddr2]);

  // Clear applies when the regfile captures a multi-cycle write; a same-address issue overrides it.
  always_comb begin
    pending_nxt = pending;
    if (we && src_m) pending_nxt[waddr] = 1'b0;
    if (iss_set)     pending_nxt[iss_waddr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      src_m <= 1'b0;
    end else if (p_win) begin
      we    <= 1'b1;
      waddr <= p_waddr;
      wdata <= p_wdata;
      src_m <= 1'b0;
    end else if (!fifo_empty) begin
      we    <= 1'b1;
      waddr <= head_dat.addr;
      wdata <= head_dat.data;
      src_m <= 1'b1;
    end else begin
      we    <= 1'b0;
      src_m <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      err     <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if ((iss_set && pending[iss_waddr]) || (p_win && pending[p_waddr])) begin
        err <= 1'b1;
      end
    end
  end

  // pipe_hold releases one edge after the starved head has been popped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      pipe_hold <= 1'b0;
    end else begin
      if (fifo_empty || fifo_pop)   wait_cnt <= '0;
      else if (wait_cnt < WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;

      if (wait_cnt == WAIT_MAX)     pipe_hold <= 1'b1;
      else if (we && src_m)         pipe_hold <= 1'b0;
    end
  end
endmodule
